dmem_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer for the word-addressed, level-sensitive data memory.
- Port 0 is the load/store unit; port 1 is the debug/DMA loader.
- Accepts byte-addressed requests over valid/ready, picks one round-robin, and holds the memory address, data and strobes stable for a fixed number of cycles.
- Returns read data or completion on a one-cycle response pulse. Checks alignment and range before any memory access.

---
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port round-robin arbiter and access sequencer for a word-addressed,
// level-sensitive data memory. Port 0 is the load/store unit and port 1 is
// the debug/DMA loader. An accepted request is checked for alignment and
// range. A good request drives the memory strobe for ACCESS_CYCLES cycles
// with address and data held stable. Each request then gets a one-cycle
// response pulse on the port that issued it.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   reqN_valid/ready           request handshake for port N (N = 0, 1)
//   reqN_write/addr/wdata      request payload (byte address)
//   rspN_valid/rdata/err       one-cycle response, read data, error flag
//   mem_addr/wdata             word index and write data to memory
//   mem_write/mem_read         memory strobes
//   mem_rdata                  memory read data
module dmem_arbiter #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int ACCESS_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state, next_state;
  logic        last_grant;
  logic        grant;
  logic        any_valid;
  logic        accept;
  logic        addr_bad;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        lat_write;
  logic        lat_port;
  logic        lat_err;
  logic [3:0]  count;
  logic [31:0] rdata_q;

  // Round-robin pick: a lone requester wins, on a tie the port that did not
  // win last time goes next.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else begin
      grant = ~last_grant;
    end
    sel_write = grant ? req1_write : req0_write;
    sel_addr  = grant ? req1_addr  : req0_addr;
    sel_wdata = grant ? req1_wdata : req0_wdata;
    // Misaligned, or any address bit above the memory's byte range is set.
    addr_bad  = (sel_addr[1:0] != 2'b00) ||
                ((sel_addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and all control outputs. The strobes and responses decode
  // only from state and latched registers, so they change only on clock
  // edges. Ready is held low during reset so no handshake is lost.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    rsp0_valid = 1'b0;
    rsp0_rdata = 32'd0;
    rsp0_err   = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_rdata = 32'd0;
    rsp1_err   = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && any_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          next_state = addr_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_write = lat_write;
        mem_read  = ~lat_write;
        if (count == 4'd0) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (lat_port) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = rdata_q;
          rsp1_err   = lat_err;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = rdata_q;
          rsp0_err   = lat_err;
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, access counter and read capture. rdata_q is cleared at
  // accept, so writes and error responses return zero without extra muxing.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      lat_write  <= 1'b0;
      lat_port   <= 1'b0;
      lat_err    <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      count      <= 4'd0;
      rdata_q    <= 32'd0;
    end else if (accept) begin
      last_grant <= grant;
      lat_port   <= grant;
      lat_write  <= sel_write;
      lat_err    <= addr_bad;
      mem_addr   <= {2'b00, sel_addr[31:2]};
      mem_wdata  <= sel_wdata;
      count      <= CNT_LOAD;
      rdata_q    <= 32'd0;
    end else if (state == ACCESS) begin
      if (count == 4'd0) begin
        if (!lat_write) begin
          rdata_q <= mem_rdata;
        end
      end else begin
        count <= count - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Bench for dmem_arbiter. It has a behavioural memory that the DUT drives.
// A transaction-level reference model derives the expected ready,
// strobe-window and response timing from each handshake cycle. A shadow
// memory gives the expected read data.
module tb_dmem_arbiter;

  localparam int AC = 2;
  localparam int MWL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic init_mem = 1'b0;

  logic [31:0] tb_mem  [0:1023];
  logic [31:0] ref_mem [0:1023];

  dmem_arbiter #(.MEM_WORDS_LOG2(MWL), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initWord(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // Level-sensitive memory: a write commits on every edge the strobe is high.
  assign mem_rdata = tb_mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= initWord(i);
    end else if (mem_write) begin
      tb_mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state: one transaction in flight at most.
  logic        have_txn = 1'b0;
  int          t_cyc, t_resp, free_cycle = 0;
  logic        t_port, t_write, t_err, m_last = 1'b1;
  logic [31:0] t_addr, t_wdata, t_rdata;

  // The model's rules come from the arbitration, latency and reset rules.
  // The arbiter accepts when idle, no earlier than the model's free cycle.
  // For a handshake at cycle T, a good request strobes during T+1..T+AC
  // and responds at T+AC+1. A bad request responds at T+1. Reset drops
  // any transaction in flight.
  always @(negedge clk) begin
    logic idle, g, er0, er1, win, at_rsp, bad;
    logic [31:0] a;
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = initWord(i);
    end
    if (mon_en) begin
      idle = !reset && (cyc >= free_cycle);
      if (req0_valid && !req1_valid) g = 1'b0;
      else if (req1_valid && !req0_valid) g = 1'b1;
      else g = !m_last;
      er0 = idle && req0_valid && !g;
      er1 = idle && req1_valid && g;
      checkOutput("req0_ready", 32'(req0_ready), 32'(er0));
      checkOutput("req1_ready", 32'(req1_ready), 32'(er1));

      win = have_txn && !t_err && (cyc >= t_cyc + 1) && (cyc <= t_cyc + AC);
      checkOutput("mem_write", 32'(mem_write), 32'(win && t_write));
      checkOutput("mem_read", 32'(mem_read), 32'(win && !t_write));
      if (win) begin
        checkOutput("mem_addr", mem_addr, t_addr >> 2);
        checkOutput("mem_wdata", mem_wdata, t_wdata);
      end

      at_rsp = have_txn && (cyc == t_resp);
      checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(at_rsp && !t_port));
      checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(at_rsp && t_port));
      checkOutput("rsp0_rdata", rsp0_rdata, (at_rsp && !t_port) ? t_rdata : 32'd0);
      checkOutput("rsp1_rdata", rsp1_rdata, (at_rsp && t_port) ? t_rdata : 32'd0);
      checkOutput("rsp0_err", 32'(rsp0_err), 32'(at_rsp && !t_port && t_err));
      checkOutput("rsp1_err", 32'(rsp1_err), 32'(at_rsp && t_port && t_err));

      if (er0 || er1) begin
        a        = g ? req1_addr : req0_addr;
        bad      = (a[1:0] != 2'b00) || (a >= 32'(4 << MWL));
        have_txn = 1'b1;
        t_cyc    = cyc;
        t_port   = g;
        t_write  = g ? req1_write : req0_write;
        t_addr   = a;
        t_wdata  = g ? req1_wdata : req0_wdata;
        t_err    = bad;
        t_resp   = bad ? cyc + 1 : cyc + AC + 1;
        free_cycle = t_resp + 1;
        t_rdata  = (bad || t_write) ? 32'd0 : ref_mem[a[11:2]];
        if (!bad && t_write) ref_mem[a[11:2]] = t_wdata;
        m_last   = g;
      end
      if (reset) begin
        have_txn   = 1'b0;
        free_cycle = cyc + 1;
        m_last     = 1'b1;
      end
    end
  end

  task automatic driveReq(input int port, input logic v, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Hold the request until ready, then drop it just after the accept edge.
  task automatic applyStimulus(input int port, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    logic done = 1'b0;
    driveReq(port, 1'b1, w, a, d);
    while (!done && n < 300) begin
      @(negedge clk);
      done = (port == 0) ? req0_ready : req1_ready;
      n++;
    end
    checkOutput("handshake_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    driveReq(port, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleCycles(2);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
      1:       return 32'h1000 + 32'($urandom_range(0, 255) << 2);
      2:       return $urandom | 32'h8000_0000;
      default: return 32'($urandom_range(0, 31) << 2);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    init_mem = 1'b1;
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    driveReq(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    idleCycles(2);
    init_mem = 1'b0;
    reset = 1'b0;
    idleCycles(2);

    $display("[TB] write then read port 0 at 0x10");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    idleCycles(4);
    applyStimulus(0, 1'b0, 32'h10, 32'd0);
    idleCycles(4);

    $display("[TB] both ports continuously valid from reset");
    doReset();
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 32'h40 + 32'(i * 4), $urandom);
      end
      begin
        for (int j = 0; j < 4; j++) applyStimulus(1, 1'b0, 32'h40 + 32'(j * 4), 32'd0);
      end
    join
    idleCycles(5);

    $display("[TB] misaligned and out-of-range requests");
    applyStimulus(1, 1'b1, 32'h13, 32'h1234_5678);
    idleCycles(3);
    applyStimulus(0, 1'b1, 32'h1000, 32'hCAFE_F00D);
    idleCycles(3);
    applyStimulus(1, 1'b0, 32'h0, 32'd0);
    idleCycles(4);

    $display("[TB] reset during the second access cycle of a read");
    driveReq(0, 1'b1, 1'b0, 32'h20, 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 50);
    checkOutput("rst_handshake", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_read_strobe", 32'(mem_read), 32'd0);
    checkOutput("rst_ready_again", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    idleCycles(5);

    $display("[TB] randomized traffic on both ports");
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          applyStimulus(0, 1'($urandom_range(0, 1)), randAddr(), $urandom);
          idleCycles($urandom_range(0, 3));
        end
      end
      begin
        for (int j = 0; j < 150; j++) begin
          applyStimulus(1, 1'($urandom_range(0, 1)), randAddr(), $urandom);
          idleCycles($urandom_range(0, 3));
        end
      end
    join
    idleCycles(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
